csr_file: RTL and testbench

- Machine-mode CSR storage and counter block at the consumer end of the writeback CSR channel.
- Takes the registered CSR write (csr_we/csr_waddr/csr_wdata) and the inst_processed retire pulse from the MEM/WB register.
- Serves a combinational read port to the execute stage.
- Takes trap-entry and mret events from the exception controller and exports trap-vector and status state to it.

---
 rtl/csr_file.sv | 182 ++++++++++++++++++
 tb/tb_csr_file.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, 64-bit cycle/instret counters and
// trap/mret status handling at the consumer end of the writeback CSR channel.
// An unimplemented read address returns zero and raises csr_raddr_illegal.
module csr_file #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HART_ID = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_we,
  input  logic [11:0]      csr_waddr,
  input  logic [WIDTH-1:0] csr_wdata,
  input  logic             inst_processed,
  input  logic [11:0]      csr_raddr,
  output logic [WIDTH-1:0] csr_rdata,
  output logic             csr_raddr_illegal,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_cause,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic [WIDTH-1:0] trap_val,
  input  logic             mret_valid,
  input  logic             irq_ext,
  input  logic             irq_timer,
  input  logic             irq_soft,
  output logic [WIDTH-1:0] mtvec_out,
  output logic [WIDTH-1:0] mepc_out,
  output logic             mstatus_mie_out,
  output logic             irq_pending_out
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_1100;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  logic        mie_bit_q, mie_bit_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mip_s;
  logic [31:0] mstatus_s;

  assign mip_s     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};
  assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};

  // Next-state: counters and CSR writes first, then mret and trap override
  // the fields they own so the per-field priority falls out of ordering.
  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, inst_processed};

    if (csr_we) begin
      case (csr_waddr)
        ADDR_MSTATUS: begin
          mie_bit_d = csr_wdata[3];
          mpie_d    = csr_wdata[7];
        end
        ADDR_MIE:       mie_d      = csr_wdata & MIE_MASK;
        ADDR_MTVEC:     mtvec_d    = align4(csr_wdata);
        ADDR_MSCRATCH:  mscratch_d = csr_wdata;
        ADDR_MEPC:      mepc_d     = align4(csr_wdata);
        ADDR_MCAUSE:    mcause_d   = csr_wdata;
        ADDR_MTVAL:     mtval_d    = csr_wdata;
        // A write to either counter half replaces the increment; the
        // other half holds its old value.
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wdata};
        ADDR_MCYCLEH:   mcycle_d   = {csr_wdata, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wdata};
        ADDR_MINSTRETH: minstret_d = {csr_wdata, minstret_q[31:0]};
        default: ;  // read-only or unimplemented: ignored
      endcase
    end else begin
      mtvec_d = mtvec_d;
    end

    if (trap_valid) begin
      mepc_d    = align4(trap_pc);
      mcause_d  = trap_cause;
      mtval_d   = trap_val;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (mret_valid) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else begin
      mpie_d = mpie_d;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Read port: straight from current state, no bypass of in-flight writes.
  always_comb begin
    csr_rdata         = 32'd0;
    csr_raddr_illegal = 1'b0;
    case (csr_raddr)
      ADDR_MSTATUS:                 csr_rdata = mstatus_s;
      ADDR_MISA:                    csr_rdata = MISA_VALUE;
      ADDR_MIE:                     csr_rdata = mie_q;
      ADDR_MTVEC:                   csr_rdata = mtvec_q;
      ADDR_MSCRATCH:                csr_rdata = mscratch_q;
      ADDR_MEPC:                    csr_rdata = mepc_q;
      ADDR_MCAUSE:                  csr_rdata = mcause_q;
      ADDR_MTVAL:                   csr_rdata = mtval_q;
      ADDR_MIP:                     csr_rdata = mip_s;
      ADDR_MCYCLE, ADDR_CYCLE:      csr_rdata = mcycle_q[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:    csr_rdata = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  csr_rdata = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: csr_rdata = minstret_q[63:32];
      ADDR_MHARTID:                 csr_rdata = 32'(HART_ID);
      default:                      csr_raddr_illegal = 1'b1;
    endcase
  end

  assign mtvec_out       = mtvec_q;
  assign mepc_out        = mepc_q;
  assign mstatus_mie_out = mie_bit_q;
  assign irq_pending_out = mie_bit_q & (|(mie_q & mip_s));

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_we = 1'b0;
  logic [11:0] csr_waddr = 12'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic        inst_processed = 1'b0;
  logic [11:0] csr_raddr = 12'd0;
  logic [31:0] csr_rdata;
  logic        csr_raddr_illegal;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_pc = 32'd0;
  logic [31:0] trap_val = 32'd0;
  logic        mret_valid = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_soft = 1'b0;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mstatus_mie_out;
  logic        irq_pending_out;

  int vectors = 0;
  int miscompares = 0;

  csr_file #(.WIDTH(32), .HART_ID(0)) dut (
    .clk(clk), .rst(rst),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .inst_processed(inst_processed),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_raddr_illegal(csr_raddr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val),
    .mret_valid(mret_valid),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out),
    .mstatus_mie_out(mstatus_mie_out), .irq_pending_out(irq_pending_out)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural state as plain words and 64-bit numbers.
  logic [31:0] m_status;   // only bits 3 (MIE) and 7 (MPIE) are ever set
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_list [0:21] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
    12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h302, 12'hB01};

  task automatic model_reset();
    m_status = 32'd0; m_mie = 32'd0; m_mtvec = 32'd0; m_mscratch = 32'd0;
    m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
    m_cycle = 64'd0; m_instret = 64'd0;
  endtask

  function automatic logic [31:0] model_mip();
    return (32'(irq_soft) << 3) | (32'(irq_timer) << 7) | (32'(irq_ext) << 11);
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    ill = 1'b0;
    case (a)
      12'h300: d = m_status | 32'h0000_1800;
      12'h301: d = 32'h4000_1100;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = model_mip();
      12'hB00, 12'hC00: d = m_cycle[31:0];
      12'hB80, 12'hC80: d = m_cycle[63:32];
      12'hB02, 12'hC02: d = m_instret[31:0];
      12'hB82, 12'hC82: d = m_instret[63:32];
      12'hF14: d = 32'd0;
      default: begin d = 32'd0; ill = 1'b1; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [11:0] a);
    logic [31:0] d;
    logic ill;
    csr_raddr = a;
    #1;
    model_read(a, d, ill);
    check($sformatf("%s rdata@%h", tag, a), csr_rdata, d);
    check($sformatf("%s illegal@%h", tag, a), {31'd0, csr_raddr_illegal}, {31'd0, ill});
  endtask

  task automatic check_outputs(input string tag);
    logic pend;
    pend = m_status[3] && ((m_mie & model_mip()) != 32'd0);
    check({tag, " mtvec_out"}, mtvec_out, m_mtvec);
    check({tag, " mepc_out"}, mepc_out, m_mepc);
    check({tag, " mie_out"}, {31'd0, mstatus_mie_out}, {31'd0, m_status[3]});
    check({tag, " pending"}, {31'd0, irq_pending_out}, {31'd0, pend});
  endtask

  // Apply one rising edge to both DUT and model using the inputs held now.
  task automatic step();
    logic [31:0] ns;
    logic [63:0] nc, ni;
    ns = m_status;
    nc = m_cycle + 64'd1;
    ni = m_instret + (inst_processed ? 64'd1 : 64'd0);
    if (csr_we) begin
      case (csr_waddr)
        12'h300: if (!trap_valid && !mret_valid) ns = csr_wdata & 32'h88;
        12'h304: m_mie = csr_wdata & 32'h888;
        12'h305: m_mtvec = csr_wdata & ~32'd3;
        12'h340: m_mscratch = csr_wdata;
        12'h341: if (!trap_valid) m_mepc = csr_wdata & ~32'd3;
        12'h342: if (!trap_valid) m_mcause = csr_wdata;
        12'h343: if (!trap_valid) m_mtval = csr_wdata;
        12'hB00: nc = (m_cycle & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
        12'hB80: nc = (64'(csr_wdata) << 32) | (m_cycle & 64'h0000_0000_FFFF_FFFF);
        12'hB02: ni = (m_instret & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
        12'hB82: ni = (64'(csr_wdata) << 32) | (m_instret & 64'h0000_0000_FFFF_FFFF);
        default: ;
      endcase
    end
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'd3;
      m_mcause = trap_cause;
      m_mtval = trap_val;
      ns = m_status[3] ? 32'h80 : 32'h00;
    end else if (mret_valid) begin
      ns = 32'h80 | (m_status[7] ? 32'h08 : 32'h00);
    end
    @(posedge clk);
    #1;
    m_status = ns; m_cycle = nc; m_instret = ni;
  endtask

  task automatic idle();
    csr_we = 1'b0; inst_processed = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset release, five idle edges
    repeat (5) step();
    check("t1 mcycle==5", dut.csr_rdata === dut.csr_rdata ? m_cycle[31:0] : 32'd0, 32'd5);
    check_read("t1", 12'hB00);
    csr_raddr = 12'hB00; #1;
    check("t1 mcycle const", csr_rdata, 32'd5);
    check_read("t1", 12'hB02);
    check_read("t1", 12'h300);
    csr_raddr = 12'h300; #1;
    check("t1 mstatus const", csr_rdata, 32'h0000_1800);
    check_read("t1", 12'h301);
    csr_raddr = 12'h7C0; #1;
    check("t1 7C0 rdata", csr_rdata, 32'd0);
    check("t1 7C0 illegal", {31'd0, csr_raddr_illegal}, 32'd1);
    check_outputs("t1");

    // 2: mtvec alignment, write to read-only cycle ignored
    wr(12'h305, 32'h8000_0103); step(); idle();
    check("t2 mtvec_out", mtvec_out, 32'h8000_0100);
    wr(12'hC00, 32'h0000_DEAD); step(); idle();
    check_read("t2", 12'hC00);
    check_read("t2", 12'hB00);

    // 3: counter carry and write-overrides-increment
    wr(12'hB00, 32'hFFFF_FFFF); step();
    wr(12'hB80, 32'h0000_0000); step(); idle();
    check_read("t3 preload", 12'hB00);
    step();
    csr_raddr = 12'hB00; #1;
    check("t3 carry low", csr_rdata, 32'd0);
    csr_raddr = 12'hB80; #1;
    check("t3 carry high", csr_rdata, 32'd1);
    wr(12'hB00, 32'h0000_0010); step(); idle();
    csr_raddr = 12'hB00; #1;
    check("t3 write low", csr_rdata, 32'h10);
    csr_raddr = 12'hB80; #1;
    check("t3 high held", csr_rdata, 32'd1);

    // 4: minstret counting and concurrent write
    inst_processed = 1'b1; step(); step();
    inst_processed = 1'b0; step();
    inst_processed = 1'b1; step(); idle();
    csr_raddr = 12'hB02; #1;
    check("t4 minstret 3", csr_rdata, 32'd3);
    inst_processed = 1'b1; step(); step();
    wr(12'hB02, 32'd7); step(); idle();
    csr_raddr = 12'hB02; #1;
    check("t4 minstret 7", csr_rdata, 32'd7);
    check_read("t4", 12'hC82);

    // 5: trap entry with colliding mepc write, then mret
    wr(12'h300, 32'h0000_0008); step(); idle();
    check("t5 mie set", {31'd0, mstatus_mie_out}, 32'd1);
    trap_valid = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'h8000_000B;
    trap_val = 32'h0000_1234;
    wr(12'h341, 32'hFFFF_0000); step(); idle();
    check("t5 mepc", mepc_out, 32'h0000_0204);
    csr_raddr = 12'h342; #1;
    check("t5 mcause", csr_rdata, 32'h8000_000B);
    csr_raddr = 12'h300; #1;
    check("t5 mstatus trap", csr_rdata, 32'h0000_1880);
    check_read("t5", 12'h343);
    mret_valid = 1'b1; step(); idle();
    csr_raddr = 12'h300; #1;
    check("t5 mstatus mret", csr_rdata, 32'h0000_1888);
    check_outputs("t5");

    // 6: pending interrupt, then asynchronous reset mid-run
    wr(12'h304, 32'h0000_0800); irq_ext = 1'b1; step(); idle();
    check("t6 pending", {31'd0, irq_pending_out}, 32'd1);
    check_read("t6", 12'h344);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t6 rst mtvec", mtvec_out, 32'd0);
    check("t6 rst mepc", mepc_out, 32'd0);
    check("t6 rst mie", {31'd0, mstatus_mie_out}, 32'd0);
    check("t6 rst pending", {31'd0, irq_pending_out}, 32'd0);
    csr_raddr = 12'h300; #1;
    check("t6 rst mstatus", csr_rdata, 32'h0000_1800);
    csr_raddr = 12'hB00; #1;
    check("t6 rst mcycle", csr_rdata, 32'd0);
    csr_raddr = 12'hB02; #1;
    check("t6 rst minstret", csr_rdata, 32'd0);
    csr_raddr = 12'h304; #1;
    check("t6 rst mie reg", csr_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; irq_ext = 1'b0;
    step();
    csr_raddr = 12'hB00; #1;
    check("t6 first inc", csr_rdata, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      csr_we         = ($urandom_range(0, 2) != 0);
      csr_waddr      = addr_list[$urandom_range(0, 21)];
      d              = $urandom;
      csr_wdata      = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : d;
      inst_processed = $urandom_range(0, 1) == 1;
      trap_valid     = ($urandom_range(0, 11) == 0);
      mret_valid     = ($urandom_range(0, 9) == 0);
      trap_pc        = $urandom;
      trap_cause     = $urandom;
      trap_val       = $urandom;
      irq_ext        = $urandom_range(0, 1) == 1;
      irq_timer      = $urandom_range(0, 1) == 1;
      irq_soft       = $urandom_range(0, 1) == 1;
      check_read("rnd", addr_list[$urandom_range(0, 21)]);
      check_outputs("rnd");
      step();
    end
    idle();
    foreach (addr_list[k]) check_read("final", addr_list[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
